// File: rtl/wb_csr_pkg.sv
// Shared types and helpers for the Wishbone CSR bank: FSM encoding,
// register access modes, and byte-enable expansion.
package wb_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RW  = 2'd0;
  localparam mode_t MODE_RO  = 2'd1;
  localparam mode_t MODE_W1C = 2'd2;

  // Widest bus the expansion helper handles; callers truncate to their width.
  localparam int MAX_BE    = 32;
  localparam int MAX_DATAW = MAX_BE * 8;

  // RO wins when a register is flagged in both masks.
  function automatic mode_t regMode(input logic roBit, input logic w1cBit);
    if (roBit) return MODE_RO;
    if (w1cBit) return MODE_W1C;
    return MODE_RW;
  endfunction

  function automatic logic [MAX_DATAW-1:0] expandByteEn(input logic [MAX_BE-1:0] byteEn);
    logic [MAX_DATAW-1:0] bitMask;
    bitMask = '0;
    for (int b = 0; b < MAX_BE; b++) begin
      bitMask[b*8 +: 8] = {8{byteEn[b]}};
    end
    return bitMask;
  endfunction

endpackage

// File: rtl/wb_csr_cell.sv
// One CSR: RW (byte-masked write), RO (reads hardware status, holds no state)
// or W1C (hardware sets, software clears; a same-cycle set beats the clear).
module wb_csr_cell
  import wb_csr_pkg::*;
#(
  parameter int    pDATAW = 32,
  parameter mode_t pMODE  = MODE_RW
) (
  input  logic              i_Clk,
  input  logic              i_SRstN,
  input  logic              i_WrEn,
  input  logic [pDATAW-1:0] iv_ByteMask,
  input  logic [pDATAW-1:0] iv_WrData,
  input  logic [pDATAW-1:0] iv_HwSet,
  input  logic [pDATAW-1:0] iv_HwStatus,
  output logic [pDATAW-1:0] ov_Value,
  output logic [pDATAW-1:0] ov_RdValue,
  output logic              o_WrPulse
);

  logic [pDATAW-1:0] regQ;
  logic [pDATAW-1:0] regD;
  logic [pDATAW-1:0] clrBits;

  // Next register value according to the access mode.
  always_comb begin
    clrBits = i_WrEn ? (iv_WrData & iv_ByteMask) : '0;
    regD    = regQ;
    case (pMODE)
      MODE_W1C: regD = (regQ & ~clrBits) | iv_HwSet;
      MODE_RO:  regD = '0;
      default: begin
        if (i_WrEn) regD = (regQ & ~iv_ByteMask) | (iv_WrData & iv_ByteMask);
      end
    endcase
  end

  // Register state and the one-cycle write pulse (never for RO).
  always_ff @(posedge i_Clk) begin
    if (!i_SRstN) begin
      regQ      <= '0;
      o_WrPulse <= 1'b0;
    end else begin
      regQ      <= regD;
      o_WrPulse <= i_WrEn && (pMODE != MODE_RO);
    end
  end

  assign ov_Value   = regQ;
  assign ov_RdValue = (pMODE == MODE_RO) ? iv_HwStatus : regQ;

endmodule

// File: rtl/wb_csr_bank.sv
// Parametrised Wishbone register bank with per-register access modes,
// 1- or 2-cycle response latency and error termination for unmapped words.
//
// state | meaning
// IDLE  | waiting for cyc&stb; the request is accepted on this edge
// WAIT  | extra latency cycle (pRDLAT=2); dropping cyc abandons it
// RESP  | one-cycle ack or err
module wb_csr_bank
  import wb_csr_pkg::*;
#(
  parameter int                   pADDRW    = 5,
  parameter int                   pNUMREGS  = 32,
  parameter int                   pDATAW    = 32,
  parameter logic [pNUMREGS-1:0]  pRO_MASK  = '0,
  parameter logic [pNUMREGS-1:0]  pW1C_MASK = '0,
  parameter int                   pRDLAT    = 1
) (
  input  logic                         i_Clk,
  input  logic                         i_SRstN,
  input  logic                         i_WbCyc,
  input  logic                         i_WbStb,
  input  logic                         i_WbWnR,
  input  logic [pADDRW-1:0]            iv_WbAddr,
  input  logic [pDATAW/8-1:0]          iv_ByteEn,
  input  logic [pDATAW-1:0]            iv_WbWrData,
  output logic [pDATAW-1:0]            ov_WbRdData,
  output logic                         o_WbAck,
  output logic                         o_WbErr,
  input  logic [pNUMREGS*pDATAW-1:0]   iv_HwStatus,
  input  logic [pNUMREGS*pDATAW-1:0]   iv_HwSet,
  output logic [pNUMREGS*pDATAW-1:0]   ov_RegOut,
  output logic [pNUMREGS-1:0]          ov_WrPulse
);

  localparam logic [pADDRW:0] NUMREGS_W = (pADDRW+1)'(pNUMREGS);

  state_t             stateQ;
  state_t             stateD;
  logic               accept;
  logic               inRange;
  logic               errQ;
  logic               readQ;
  logic [pDATAW-1:0]  byteMask;
  logic [pDATAW-1:0]  rdSel;
  logic [pDATAW-1:0]  rdNext;
  logic [pDATAW-1:0]  rdSampleQ;
  logic [pDATAW-1:0]  rdDataQ;
  logic [pNUMREGS-1:0] wrEn;
  logic [pDATAW-1:0]  rdVals [pNUMREGS];

  assign byteMask = pDATAW'(expandByteEn(MAX_BE'(iv_ByteEn)));
  assign inRange  = {1'b0, iv_WbAddr} < NUMREGS_W;
  assign accept   = (stateQ == ST_IDLE) && i_WbCyc && i_WbStb;

  // Address decode: per-register write enable and read mux (0 when unmapped).
  always_comb begin
    wrEn  = '0;
    rdSel = '0;
    for (int n = 0; n < pNUMREGS; n++) begin
      if (iv_WbAddr == pADDRW'(n)) begin
        wrEn[n] = accept && i_WbWnR;
        rdSel   = rdVals[n];
      end
    end
  end

  assign rdNext = rdSel & byteMask;

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE: if (accept) stateD = (pRDLAT == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: stateD = i_WbCyc ? ST_RESP : ST_IDLE;
      ST_RESP: stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  // State register plus captured request attributes and read-data holding.
  always_ff @(posedge i_Clk) begin
    if (!i_SRstN) begin
      stateQ    <= ST_IDLE;
      errQ      <= 1'b0;
      readQ     <= 1'b0;
      rdSampleQ <= '0;
      rdDataQ   <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        errQ      <= !inRange;
        readQ     <= !i_WbWnR;
        rdSampleQ <= rdNext;
      end
      // Read data only changes on entry to RESP for a read.
      if (stateD == ST_RESP) begin
        if (stateQ == ST_IDLE) begin
          if (!i_WbWnR) rdDataQ <= rdNext;
        end else if (readQ) begin
          rdDataQ <= rdSampleQ;
        end
      end
    end
  end

  assign o_WbAck     = (stateQ == ST_RESP) && !errQ;
  assign o_WbErr     = (stateQ == ST_RESP) && errQ;
  assign ov_WbRdData = rdDataQ;

  for (genvar n = 0; n < pNUMREGS; n++) begin : gCell
    wb_csr_cell #(
      .pDATAW(pDATAW),
      .pMODE (regMode(pRO_MASK[n], pW1C_MASK[n]))
    ) uCell (
      .i_Clk      (i_Clk),
      .i_SRstN    (i_SRstN),
      .i_WrEn     (wrEn[n]),
      .iv_ByteMask(byteMask),
      .iv_WrData  (iv_WbWrData),
      .iv_HwSet   (iv_HwSet[n*pDATAW +: pDATAW]),
      .iv_HwStatus(iv_HwStatus[n*pDATAW +: pDATAW]),
      .ov_Value   (ov_RegOut[n*pDATAW +: pDATAW]),
      .ov_RdValue (rdVals[n]),
      .o_WrPulse  (ov_WrPulse[n])
    );
  end

endmodule

// File: tb/tb_wb_csr_bank.sv
// Bench for wb_csr_bank: two instances (latency 1 and 2) sharing the bus
// payload and hardware inputs, each with its own cyc/stb, checked against a
// per-register behavioural model.
module tb_wb_csr_bank;

  localparam int NREG = 20;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam logic [NREG-1:0] RO_M  = 20'h01080;  // regs 7, 12
  localparam logic [NREG-1:0] W1C_M = 20'h01220;  // regs 5, 9, 12 (12 stays RO)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  logic cyc0, stb0, cyc1, stb1, wbWnR;
  logic [AW-1:0]      wbAddr;
  logic [3:0]         byteEn;
  logic [DW-1:0]      wrData;
  logic [NREG*DW-1:0] hwStatus, hwSet;
  logic [DW-1:0]      rd0, rd1;
  logic               ack0, ack1, err0, err1;
  logic [NREG*DW-1:0] regOut0, regOut1;
  logic [NREG-1:0]    wp0, wp1;

  int nChecks = 0;
  int nErrs   = 0;

  logic [DW-1:0] refReg [2][NREG];
  logic [DW-1:0] lastRd [2];
  int            expPulse [2][NREG];
  int            pcnt [2][NREG];

  wb_csr_bank #(.pADDRW(AW), .pNUMREGS(NREG), .pDATAW(DW), .pRO_MASK(RO_M),
                .pW1C_MASK(W1C_M), .pRDLAT(1)) dut0 (
    .i_Clk(clk), .i_SRstN(rstN), .i_WbCyc(cyc0), .i_WbStb(stb0), .i_WbWnR(wbWnR),
    .iv_WbAddr(wbAddr), .iv_ByteEn(byteEn), .iv_WbWrData(wrData),
    .ov_WbRdData(rd0), .o_WbAck(ack0), .o_WbErr(err0),
    .iv_HwStatus(hwStatus), .iv_HwSet(hwSet), .ov_RegOut(regOut0), .ov_WrPulse(wp0));

  wb_csr_bank #(.pADDRW(AW), .pNUMREGS(NREG), .pDATAW(DW), .pRO_MASK(RO_M),
                .pW1C_MASK(W1C_M), .pRDLAT(2)) dut1 (
    .i_Clk(clk), .i_SRstN(rstN), .i_WbCyc(cyc1), .i_WbStb(stb1), .i_WbWnR(wbWnR),
    .iv_WbAddr(wbAddr), .iv_ByteEn(byteEn), .iv_WbWrData(wrData),
    .ov_WbRdData(rd1), .o_WbAck(ack1), .o_WbErr(err1),
    .iv_HwStatus(hwStatus), .iv_HwSet(hwSet), .ov_RegOut(regOut1), .ov_WrPulse(wp1));

  // Count every cycle a write pulse is seen high.
  always @(negedge clk) begin
    for (int n = 0; n < NREG; n++) begin
      if (wp0[n]) pcnt[0][n]++;
      if (wp1[n]) pcnt[1][n]++;
    end
  end

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beMask(input logic [3:0] be);
    logic [DW-1:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic obsAck(input int d);
    return (d == 1) ? ack1 : ack0;
  endfunction

  function automatic logic obsErr(input int d);
    return (d == 1) ? err1 : err0;
  endfunction

  function automatic logic [DW-1:0] obsRd(input int d);
    return (d == 1) ? rd1 : rd0;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      lastRd[d] = '0;
      for (int n = 0; n < NREG; n++) refReg[d][n] = '0;
    end
  endtask

  // One clock edge worth of register updates across both banks.
  task automatic modelEdge(input int d, input bit we, input int a, input logic [3:0] be,
                           input logic [DW-1:0] wd, input logic [NREG*DW-1:0] setv);
    logic [DW-1:0] m, clr;
    m = beMask(be);
    for (int dd = 0; dd < 2; dd++) begin
      for (int n = 0; n < NREG; n++) begin
        bit hit;
        hit = (dd == d) && we && (a == n);
        clr = hit ? (wd & m) : '0;
        if (!RO_M[n]) begin
          if (W1C_M[n]) refReg[dd][n] = (refReg[dd][n] & ~clr) | setv[n*DW +: DW];
          else if (hit) refReg[dd][n] = (refReg[dd][n] & ~m) | (wd & m);
        end
      end
    end
    if (d >= 0 && we && a < NREG) begin
      if (!RO_M[a]) expPulse[d][a]++;
    end
  endtask

  task automatic pulseSet(input logic [NREG*DW-1:0] setv);
    hwSet = setv;
    @(posedge clk);
    modelEdge(-1, 1'b0, 0, 4'h0, '0, setv);
    #1;
    hwSet = '0;
  endtask

  task automatic busXfer(input int d, input bit we, input int a, input logic [3:0] be,
                         input logic [DW-1:0] wd, input logic [NREG*DW-1:0] setv);
    logic [DW-1:0] expRd;
    bit oor;
    int lat;
    oor   = (a >= NREG);
    expRd = '0;
    if (!oor) expRd = (RO_M[a] ? hwStatus[a*DW +: DW] : refReg[d][a]) & beMask(be);
    wbWnR  = we;
    wbAddr = a[AW-1:0];
    byteEn = be;
    wrData = wd;
    hwSet  = setv;
    if (d == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else        begin cyc0 = 1'b1; stb0 = 1'b1; end
    @(posedge clk);
    modelEdge(d, we, a, be, wd, setv);
    #1;
    hwSet = '0;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      if (obsAck(d) || obsErr(d)) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!we) lastRd[d] = expRd;
    chkVal($sformatf("lat d%0d a%0d", d, a), lat, (d == 1) ? 2 : 1);
    chkVal($sformatf("ack d%0d a%0d", d, a), obsAck(d), !oor);
    chkVal($sformatf("err d%0d a%0d", d, a), obsErr(d), oor);
    chkVal($sformatf("rdata d%0d a%0d we%0d", d, a, we), obsRd(d), lastRd[d]);
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge clk);
    #1;
    chkVal($sformatf("resp_1cyc d%0d", d), {obsErr(d), obsAck(d)}, 0);
  endtask

  task automatic checkAll(input int d);
    for (int n = 0; n < NREG; n++) begin
      chkVal($sformatf("regout d%0d r%0d", d, n),
             (d == 1) ? regOut1[n*DW +: DW] : regOut0[n*DW +: DW],
             RO_M[n] ? 32'h0 : refReg[d][n]);
      chkVal($sformatf("pulses d%0d r%0d", d, n), pcnt[d][n], expPulse[d][n]);
    end
  endtask

  initial begin
    logic [NREG*DW-1:0] setv;
    rstN = 1'b0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    wbWnR = 1'b0; wbAddr = '0; byteEn = '0; wrData = '0; hwSet = '0;
    for (int n = 0; n < NREG; n++) hwStatus[n*DW +: DW] = $urandom;
    hwStatus[7*DW +: DW] = 32'hDEADBEEF;
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < NREG; n++) begin expPulse[d][n] = 0; pcnt[d][n] = 0; end
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    chkVal("rst ack0", ack0, 0);
    chkVal("rst err0", err0, 0);
    chkVal("rst rd0", rd0, 0);
    chkVal("rst wp0", wp0, 0);
    chkVal("rst ack1", ack1, 0);
    chkVal("rst rd1", rd1, 0);
    checkAll(0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // RW read/write with byte enables
    busXfer(0, 0, 0, 4'hF, '0, '0);
    busXfer(0, 1, 3, 4'b0101, 32'hA5A5A5A5, '0);
    busXfer(0, 0, 3, 4'hF, '0, '0);
    chkVal("rw3 read", rd0, 32'h00A500A5);
    chkVal("rw3 regout", regOut0[3*DW +: DW], 32'h00A500A5);
    chkVal("rw3 pulse count", pcnt[0][3], 1);

    // W1C: hardware set, software clear, and set winning over clear
    setv = '0;
    setv[5*DW +: DW] = 32'h0000000F;
    pulseSet(setv);
    busXfer(0, 0, 5, 4'hF, '0, '0);
    chkVal("w1c set read", rd0, 32'h0000000F);
    busXfer(0, 1, 5, 4'hF, 32'h3, '0);
    busXfer(0, 0, 5, 4'hF, '0, '0);
    chkVal("w1c clear read", rd0, 32'h0000000C);
    setv = '0;
    setv[5*DW +: DW] = 32'h4;
    busXfer(0, 1, 5, 4'hF, 32'h4, setv);
    busXfer(0, 0, 5, 4'hF, '0, '0);
    chkVal("w1c set beats clear", rd0, 32'h0000000C);

    // RO register
    busXfer(0, 0, 7, 4'b1100, '0, '0);
    chkVal("ro partial read", rd0, 32'hDEAD0000);
    busXfer(0, 1, 7, 4'hF, 32'h0, '0);
    busXfer(0, 0, 7, 4'hF, '0, '0);
    chkVal("ro full read", rd0, 32'hDEADBEEF);
    chkVal("ro no pulse", pcnt[0][7], 0);

    // Out-of-range address
    busXfer(0, 1, 25, 4'hF, 32'hFFFFFFFF, '0);
    busXfer(0, 0, 25, 4'hF, '0, '0);
    chkVal("oor read data", rd0, 32'h0);
    checkAll(0);

    // Latency-2 instance: normal access, abandoned wait, reset during wait
    busXfer(1, 1, 3, 4'hF, 32'h12345678, '0);
    busXfer(1, 0, 3, 4'hF, '0, '0);
    chkVal("lat2 read", rd1, 32'h12345678);
    wbWnR = 1'b0; wbAddr = 5'd0; byteEn = 4'hF;
    cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk);
    #1;
    cyc1 = 1'b0; stb1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chkVal("abort no resp", {err1, ack1}, 0);
      @(posedge clk);
      #1;
    end
    chkVal("abort rdata held", rd1, lastRd[1]);
    busXfer(1, 0, 3, 4'hF, '0, '0);

    wbWnR = 1'b0; wbAddr = 5'd3; byteEn = 4'hF;
    cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk);
    #1;
    rstN = 1'b0;
    cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge clk);
    modelReset();
    #1;
    chkVal("wait rst ack", ack1, 0);
    chkVal("wait rst err", err1, 0);
    chkVal("wait rst rd", rd1, 0);
    chkVal("wait rst wp", wp1, 0);
    checkAll(1);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chkVal("post rst no resp", {err1, ack1}, 0);

    // Randomised traffic on both instances
    for (int i = 0; i < 120; i++) begin
      int d, a;
      bit we;
      d  = $urandom_range(0, 1);
      we = $urandom_range(0, 1);
      a  = $urandom_range(0, 24);
      setv = '0;
      if ($urandom_range(0, 3) == 0)
        for (int n = 0; n < NREG; n++) setv[n*DW +: DW] = $urandom & $urandom;
      if ($urandom_range(0, 4) == 0)
        for (int n = 0; n < NREG; n++) hwStatus[n*DW +: DW] = $urandom;
      busXfer(d, we, a, 4'($urandom), $urandom, setv);
      if (i % 20 == 19) begin
        checkAll(0);
        checkAll(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
    $finish;
  end

endmodule
